mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter, WAIT_CYCLES, default 2, giving the memory access cycles per transfer; legal range is 1..15.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-fetch request (the control unit's MOV during fetch).
- i_addr  in  32  fetch address (the PC).
- i_moc  out  1  fetch memory-operation-complete pulse.
- i_rdata  out  32  fetched word, to the IR.
- d_req  in  1  data request.
- d_rw  in  1  1 = read, 0 = write.
- d_size  in  2  00 byte, 01 halfword, 10 word.
- d_addr  in  32  data address (the MAR).
- d_wdata  in  32  store data (the MDR).
- d_moc  out  1  data completion pulse (DMOC).
- d_rdata  out  32  load data, to the MDR.
- err  out  1  misaligned-access flag, valid with the moc pulse.
- mem_en  out  1  memory enable.
- mem_rw  out  1  memory read/write.
- mem_size  out  2  memory access size.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- busy  out  1  high when the FSM is not IDLE.

Function
REQ-003 The FSM SHALL have four states, IDLE, ACC_I, ACC_D and DONE, encoded 2'b00..2'b11.
REQ-004 In IDLE, when d_req is high, the FSM SHALL go to ACC_D; otherwise, when i_req is high, it SHALL go to ACC_I. Data has fixed priority.
REQ-005 On leaving IDLE, the block SHALL latch the address, rw, size and wdata of the granted port; mem_* outputs SHALL drive only these latched values.
REQ-006 mem_en SHALL be high in every ACC_x cycle and low in all other states; a fetch SHALL drive mem_rw=1 and mem_size=10.
REQ-007 A wait counter SHALL load WAIT_CYCLES-1 on entry to ACC_x and decrement each cycle; the FSM SHALL go to DONE when the count is 0.
REQ-008 In the final ACC_x cycle of a read, mem_rdata SHALL be captured into i_rdata or d_rdata; the captured value SHALL hold until the next completed read on that port.
REQ-009 In DONE, the granted port's moc SHALL be high for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-010 Latency SHALL be WAIT_CYCLES+2 cycles from the first clock edge that samples req to the moc pulse.
REQ-011 A requester SHALL hold req until it sees moc. If req drops mid-access, the access SHALL still complete and moc SHALL still pulse.
REQ-012 If req is still high in the cycle after DONE, the block SHALL treat it as a new request, arbitrated again in IDLE.
REQ-013 When both requests rise in the same cycle, the data access SHALL be served first and the fetch SHALL follow with no idle cycle beyond DONE.
REQ-014 The block SHALL NOT pulse i_moc and d_moc in the same cycle.

Reset
REQ-015 While reset is low, the FSM SHALL be in IDLE, the counter 0, and all outputs 0, including i_rdata and d_rdata. mem_en SHALL drop asynchronously, including mid-access.
REQ-016 An access interrupted by reset SHALL be abandoned; no moc pulse SHALL follow.

Configuration
REQ-017 With MEM_ARBITER_ALIGN_CHECK_EN defined, a data access with d_size=01 and addr[0]=1, or d_size=10 and addr[1:0]!=0, SHALL skip ACC_D and go straight to DONE. It SHALL then pulse d_moc with err=1, leave mem_en low and leave d_rdata unchanged.
REQ-018 Without MEM_ARBITER_ALIGN_CHECK_EN, err SHALL be tied 0 and all accesses SHALL go to memory unchecked.

Structure
REQ-019 The shared package mem_arbiter_pkg SHALL hold the state encodings, the size codes (BYTE/HALF/WORD) and the WAIT_CYCLES maximum.
REQ-020 The wait counter SHALL be a sub-module named mem_wait_counter, with load, decrement and zero-flag functions.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Fetch i_addr=0x0000_0004 with mem_rdata=0x2001_0005 and WAIT_CYCLES=2 -> mem_en high for 2 cycles, i_moc pulses at cycle 4, i_rdata=0x2001_0005.
- i_req and d_req rise together, d write 0xDEAD_BEEF to 0x10 -> write completes first (d_moc), i_moc follows 4 cycles later, and the moc signals never overlap.
- Reset driven low in the second ACC_D cycle -> mem_en drops immediately, busy=0, no d_moc after reset releases.
- With MEM_ARBITER_ALIGN_CHECK_EN, word read at 0x0000_0006 -> d_moc and err at cycle 2, mem_en never asserted; without the macro, a normal access with err=0.
- i_req held high across 3 fetches -> 3 i_moc pulses spaced WAIT_CYCLES+2 cycles apart, busy low for one cycle between each.
- WAIT_CYCLES=1, byte read -> mem_size=00, d_moc at cycle 3.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states, access
// size codes, wait-counter sizing and the latched memory request.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACC_I = 2'b01,
        ST_ACC_D = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);

    typedef struct packed {
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Halfwords need even addresses, words need 4-byte alignment; bytes never fault.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that paces a memory transfer: load on access entry, count
// down while the access is in flight, flag zero on the final cycle.
module mem_wait_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LOAD_VAL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter between instruction fetch and data ports sharing one
// memory. Define MEM_ARBITER_ALIGN_CHECK_EN to reject misaligned data accesses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_moc,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_moc,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_e      state_q, state_d;
    mem_req_t    req_q, req_d;
    logic        grant_data_q, grant_data_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        cnt_load, cnt_dec, cnt_zero;
    logic        d_misaligned;

    mem_wait_counter #(
        .LOAD_VAL (WAIT_CYCLES - 1)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero)
    );

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
    logic err_q;

    assign d_misaligned = misaligned(d_size, d_addr[1:0]);

    // Captured at grant time; only meaningful while the DONE pulse is out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            err_q <= d_req & d_misaligned;
        end
    end

    assign err = err_q & (state_q == ST_DONE);
`else
    assign d_misaligned = 1'b0;
    assign err          = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        grant_data_d = grant_data_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_req) begin
                    req_d        = '{rw: d_rw, size: d_size, addr: d_addr, wdata: d_wdata};
                    grant_data_d = 1'b1;
                    if (d_misaligned) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_ACC_D;
                        cnt_load = 1'b1;
                    end
                end else if (i_req) begin
                    req_d        = '{rw: 1'b1, size: SZ_WORD, addr: i_addr, wdata: '0};
                    grant_data_d = 1'b0;
                    state_d      = ST_ACC_I;
                    cnt_load     = 1'b1;
                end
            end
            ST_ACC_I, ST_ACC_D: begin
                if (cnt_zero) begin
                    state_d = ST_DONE;
                    // Memory data is valid in the last access cycle.
                    if (req_q.rw) begin
                        if (state_q == ST_ACC_I) begin
                            i_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            grant_data_q <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            grant_data_q <= grant_data_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Decoded straight from the state register so reset kills mem_en at once.
    assign mem_en    = (state_q == ST_ACC_I) || (state_q == ST_ACC_D);
    assign mem_rw    = req_q.rw;
    assign mem_size  = req_q.size;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

    assign i_moc   = (state_q == ST_DONE) & ~grant_data_q;
    assign d_moc   = (state_q == ST_DONE) &  grant_data_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
